// File: rtl/hsv_color_tracker.sv
// hsv_color_tracker: per-frame HSV window classifier with pixel count
// and bounding box, published once per completed frame.
module hsv_color_tracker #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int MIN_PIXELS = 16,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          in_valid,
  input  logic [7:0]    h,
  input  logic [5:0]    s,
  input  logic [5:0]    v,
  input  logic [7:0]    h_lo,
  input  logic [7:0]    h_hi,
  input  logic [5:0]    s_min,
  input  logic [5:0]    v_min,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [15:0]   pix_count,
  output logic          found,
  output logic          result_valid
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [15:0]   MIN_N  = 16'(MIN_PIXELS);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t        state;
  logic [7:0]    lo_q, hi_q;
  logic [5:0]    smin_q, vmin_q;
  logic [XW-1:0] x_q, bx_min_q, bx_max_q;
  logic [YW-1:0] y_q, by_min_q, by_max_q;
  logic [15:0]   cnt_q;

  logic [7:0]    lo, hi;
  logic [5:0]    smin, vmin;
  logic          active, take, hue_ok, hit, last, found_n;
  logic [XW-1:0] px, bx_min_b, bx_max_b, bx_min_n, bx_max_n;
  logic [YW-1:0] py, by_min_b, by_max_b, by_min_n, by_max_n;
  logic [15:0]   cnt_b, cnt_n;

  // A frame_start pixel uses the fresh thresholds and cleared accumulators
  always_comb begin
    lo       = frame_start ? h_lo  : lo_q;
    hi       = frame_start ? h_hi  : hi_q;
    smin     = frame_start ? s_min : smin_q;
    vmin     = frame_start ? v_min : vmin_q;
    active   = frame_start || (state == ACCUM);
    take     = in_valid && active;
    px       = frame_start ? '0 : x_q;
    py       = frame_start ? '0 : y_q;
    cnt_b    = frame_start ? '0 : cnt_q;
    bx_min_b = frame_start ? '1 : bx_min_q;
    bx_max_b = frame_start ? '0 : bx_max_q;
    by_min_b = frame_start ? '1 : by_min_q;
    by_max_b = frame_start ? '0 : by_max_q;
    if (lo <= hi) hue_ok = (h >= lo) && (h <= hi);
    else          hue_ok = (h >= lo) || (h <= hi);
    hit      = take && hue_ok && (s >= smin) && (v >= vmin);
    cnt_n    = cnt_b + 16'(hit && (cnt_b != 16'hFFFF));
    bx_min_n = (hit && px < bx_min_b) ? px : bx_min_b;
    bx_max_n = (hit && px > bx_max_b) ? px : bx_max_b;
    by_min_n = (hit && py < by_min_b) ? py : by_min_b;
    by_max_n = (hit && py > by_max_b) ? py : by_max_b;
    last     = take && (px == X_LAST) && (py == Y_LAST);
    found_n  = cnt_n >= MIN_N;
  end

  // Frame FSM, accumulators and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      smin_q       <= '0;
      vmin_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      bx_min_q     <= '0;
      bx_max_q     <= '0;
      by_min_q     <= '0;
      by_max_q     <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      pix_count    <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (frame_start) begin
        lo_q   <= h_lo;
        hi_q   <= h_hi;
        smin_q <= s_min;
        vmin_q <= v_min;
      end
      if (active) begin
        cnt_q    <= cnt_n;
        bx_min_q <= bx_min_n;
        bx_max_q <= bx_max_n;
        by_min_q <= by_min_n;
        by_max_q <= by_max_n;
        if (take) begin
          if (px == X_LAST) begin
            x_q <= '0;
            y_q <= py + 1'b1;
          end else begin
            x_q <= px + 1'b1;
            y_q <= py;
          end
        end else begin
          x_q <= px;
          y_q <= py;
        end
        state <= last ? IDLE : ACCUM;
        if (last) begin
          pix_count    <= cnt_n;
          found        <= found_n;
          x_min        <= found_n ? bx_min_n : '0;
          x_max        <= found_n ? bx_max_n : '0;
          y_min        <= found_n ? by_min_n : '0;
          y_max        <= found_n ? by_max_n : '0;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_color_tracker.sv
// tb_hsv_color_tracker: directed vectors for the HSV blob tracker
// on an 8x4 frame with MIN_PIXELS=2.
module tb_hsv_color_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] h = '0;
  logic [5:0] s = '0;
  logic [5:0] v = '0;
  logic [7:0] h_lo = 8'd20;
  logic [7:0] h_hi = 8'd40;
  logic [5:0] s_min = 6'd10;
  logic [5:0] v_min = 6'd10;
  logic [2:0] x_min, x_max;
  logic [1:0] y_min, y_max;
  logic [15:0] pix_count;
  logic       found, result_valid;

  hsv_color_tracker #(
    .IMG_W(8), .IMG_H(4), .MIN_PIXELS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .in_valid(in_valid),
    .h(h), .s(s), .v(v),
    .h_lo(h_lo), .h_hi(h_hi),
    .s_min(s_min), .v_min(v_min),
    .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max),
    .pix_count(pix_count), .found(found),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int rv_count = 0;
  int rv_base;

  logic [7:0] ph [32];
  logic [5:0] ps [32];
  logic [5:0] pv [32];

  always @(posedge clk) if (result_valid) rv_count <= rv_count + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic fill(input logic [7:0] hv);
    for (int i = 0; i < 32; i++) begin
      ph[i] = hv;
      ps[i] = 6'd40;
      pv[i] = 6'd40;
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // gap = cycles between pixel strobes; fs0 puts frame_start on pixel 0
  task automatic run_pixels(input int gap, input bit fs0,
                            input int first, input int n,
                            input bit disturb);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (gap - 1) begin
          @(negedge clk);
          in_valid = 1'b0;
          frame_start = 1'b0;
        end
      end
      @(negedge clk);
      frame_start = fs0 && (i == 0);
      in_valid = 1'b1;
      h = ph[first + i];
      s = ps[first + i];
      v = pv[first + i];
      if (disturb && i == 1) begin
        h_lo = 8'd0;
        h_hi = 8'd0;
        s_min = 6'd63;
        v_min = 6'd63;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int cnt, input int fnd,
                            input int x0, input int x1,
                            input int y0, input int y1);
    chk({tag, "_rv"}, int'(result_valid), 1);
    chk({tag, "_cnt"}, int'(pix_count), cnt);
    chk({tag, "_found"}, int'(found), fnd);
    chk({tag, "_xmin"}, int'(x_min), x0);
    chk({tag, "_xmax"}, int'(x_max), x1);
    chk({tag, "_ymin"}, int'(y_min), y0);
    chk({tag, "_ymax"}, int'(y_max), y1);
    @(negedge clk);
    chk({tag, "_rv_width"}, int'(result_valid), 0);
  endtask

  task automatic set_blob();
    fill(8'd100);
    ph[10] = 8'd30;
    ph[13] = 8'd30;
    ph[19] = 8'd30;
  endtask

  task automatic set_thr(input logic [7:0] lo, input logic [7:0] hi);
    h_lo = lo;
    h_hi = hi;
    s_min = 6'd10;
    v_min = 6'd10;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cnt", int'(pix_count), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_box", int'({x_min, x_max, y_min, y_max}), 0);
    chk("rst_rv", int'(result_valid), 0);
    rst = 1'b0;

    // pixels with no frame_start are ignored
    set_blob();
    run_pixels(1, 1'b0, 0, 32, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_rv", rv_count, 0);
    chk("idle_cnt", int'(pix_count), 0);

    // single blob, back-to-back
    set_thr(8'd20, 8'd40);
    pulse_fs();
    rv_base = rv_count;
    run_pixels(1, 1'b0, 0, 31, 1'b0);
    chk("blob_early_rv", rv_count - rv_base, 0);
    run_pixels(1, 1'b0, 31, 1, 1'b0);
    chk_result("blob", 3, 1, 2, 5, 1, 2);

    // pixels after completion are dropped and outputs hold
    fill(8'd30);
    run_pixels(1, 1'b0, 0, 32, 1'b0);
    repeat (2) @(negedge clk);
    chk("post_rv", rv_count - rv_base, 1);
    chk("post_hold", int'(pix_count), 3);

    // hue wrap-around window
    set_thr(8'd240, 8'd10);
    fill(8'd100);
    ph[0] = 8'd250;
    ph[7] = 8'd5;
    ph[20] = 8'd128;
    pulse_fs();
    run_pixels(1, 1'b0, 0, 32, 1'b0);
    chk_result("wrap", 2, 1, 0, 7, 0, 0);

    // single match below MIN_PIXELS; low saturation rejected
    set_thr(8'd20, 8'd40);
    fill(8'd100);
    ph[28] = 8'd30;
    ph[5] = 8'd30;
    ps[5] = 6'd9;
    pulse_fs();
    run_pixels(1, 1'b0, 0, 32, 1'b0);
    chk_result("below", 1, 0, 0, 0, 0, 0);

    // restart after 10 all-matching pixels
    fill(8'd30);
    pulse_fs();
    rv_base = rv_count;
    run_pixels(1, 1'b0, 0, 10, 1'b0);
    set_blob();
    pulse_fs();
    run_pixels(1, 1'b0, 0, 22, 1'b0);
    chk("restart_early_rv", rv_count - rv_base, 0);
    run_pixels(1, 1'b0, 22, 10, 1'b0);
    chk_result("restart", 3, 1, 2, 5, 1, 2);

    // gapped stream, frame_start on pixel 0, thresholds changed mid-frame
    set_thr(8'd20, 8'd40);
    run_pixels(5, 1'b1, 0, 32, 1'b1);
    chk_result("gap", 3, 1, 2, 5, 1, 2);

    // reset mid-frame discards everything
    set_thr(8'd20, 8'd40);
    fill(8'd30);
    pulse_fs();
    run_pixels(1, 1'b0, 0, 20, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_cnt", int'(pix_count), 0);
    chk("mrst_found", int'(found), 0);
    @(negedge clk);
    rst = 1'b0;
    rv_base = rv_count;
    run_pixels(1, 1'b0, 20, 12, 1'b0);
    repeat (3) @(negedge clk);
    chk("mrst_rv", rv_count - rv_base, 0);
    chk("mrst_hold", int'(pix_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hsv_color_tracker.md
# hsv_color_tracker

Per-frame colour-blob tracker that sits directly downstream of `rgb_to_hsv`. It consumes the per-pixel `h`/`s`/`v` stream with its `out_valid` strobe and classifies each pixel against a programmable HSV window. It accumulates the matching-pixel count and bounding box over one frame, then publishes a registered result with a one-cycle `result_valid` pulse. The hexapod controller uses the result to steer towards the target colour.

## Interface
- `IMG_W`, default 160: pixels per line.
- `IMG_H`, default 120: lines per frame.
- `MIN_PIXELS`, default 16: minimum match count for `found`.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse, start of a new frame.
- `in_valid` in 1: pixel strobe, driven from `rgb_to_hsv` `out_valid`.
- `h` in 8: hue.
- `s` in 6: saturation.
- `v` in 6: value.
- `h_lo`, `h_hi` in 8 each: hue window bounds, inclusive.
- `s_min` in 6: minimum saturation, inclusive.
- `v_min` in 6: minimum value, inclusive.
- `x_min`, `x_max` out `$clog2(IMG_W)`: bounding-box columns.
- `y_min`, `y_max` out `$clog2(IMG_H)`: bounding-box rows.
- `pix_count` out 16: matching pixels in the last completed frame.
- `found` out 1: `pix_count >= MIN_PIXELS`.
- `result_valid` out 1: one-cycle pulse when the outputs update.

## Operation
- State machine with two states, IDLE and ACCUM.
  - Reset enters IDLE.
  - IDLE ignores `in_valid`. `frame_start` moves to ACCUM.
  - ACCUM returns to IDLE after the last pixel of the frame, (`IMG_W`-1, `IMG_H`-1).
- On `frame_start`:
  - latch `h_lo`, `h_hi`, `s_min`, `v_min` into internal registers; threshold changes mid-frame have no effect;
  - clear the x/y counters to 0, the count to 0, and the box accumulators to min=all-ones, max=0.
- `frame_start` in ACCUM abandons the current frame: no `result_valid`, and accumulation restarts.
- If `frame_start` and `in_valid` occur in the same cycle, that pixel is pixel (0,0) of the new frame and is classified with the newly latched thresholds.
- Match rule: `s >= s_min` AND `v >= v_min` AND a hue test.
  - If `h_lo <= h_hi`: `h_lo <= h <= h_hi`.
  - If `h_lo > h_hi` (red wrap-around): `h >= h_lo` OR `h <= h_hi`.
- On a match:
  - increment the count, saturating at 16'hFFFF;
  - update the box: x_min = min(x_min, x), x_max = max(x_max, x), and the same for y.
- Coordinates advance on each `in_valid` in ACCUM.
  - x wraps from `IMG_W`-1 to 0 and increments y.
  - After the pixel at (`IMG_W`-1, `IMG_H`-1), the frame is complete.
- On frame completion:
  - copy the accumulators to the outputs;
  - assert `result_valid`;
  - `found` = count ≥ `MIN_PIXELS`;
  - if `found`=0, drive the box outputs to 0. `pix_count` still reports the true count.
- Outputs hold their values until the next completed frame.

## Timing
- Every output resets to 0.
- Internal state resets to IDLE with thresholds of 0.
- One pixel per cycle is accepted; back-to-back `in_valid` is legal. Sparse `in_valid` (the converter's multicycle cadence) is also legal.
- `result_valid` is high for exactly one cycle: the cycle after the edge that accepts the last pixel. The new output values are visible in that same cycle.
- The last pixel's own match is included in the result.
- `rst` mid-frame discards all state immediately. No `result_valid` is produced.
- `in_valid` in IDLE, including after frame completion and before the next `frame_start`, is dropped.

## Test plan
- Bench parameters: `IMG_W`=8, `IMG_H`=4, `MIN_PIXELS`=2. Thresholds `h_lo`=20, `h_hi`=40, `s_min`=10, `v_min`=10 unless stated.
- Reset: hold `rst`, then release. All outputs are 0. 32 pixels sent without `frame_start` produce no `result_valid`.
- Single blob: matching pixels (h=30, s=40, v=40) at (2,1), (5,1), (3,2); all other pixels h=100. Expected: `pix_count`=3, `found`=1, box x 2..5, y 1..2, `result_valid` 1 cycle after pixel 31.
- Hue wrap: `h_lo`=240, `h_hi`=10. Pixels with h=250 and h=5 match; h=128 does not. Expected `pix_count`=2.
- Below minimum: one match only. Expected `pix_count`=1, `found`=0, box outputs 0. Also: s=9 with h=30 does not match.
- Mid-frame `frame_start` after 10 pixels: no `result_valid` until 32 further pixels. The result counts only post-restart matches.
- Gapped stream: `in_valid` every 5th cycle, and a `frame_start` coincident with the first pixel. The result matches the back-to-back run with identical data.
